// File: rtl/shift_register_serdes.sv
// Bidirectional shift-register SERDES: serial in/out MSB- or LSB-first with parallel load,
// per-word bit counting and a valid/ready output port for completed received words.
module shift_register_serdes #(
    parameter int       WIDTH     = 8,
    parameter bit       MSB_FIRST = 1'b1,
    localparam int      CW        = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             advance_i,
    input  logic             bit_i,
    output logic             bit_o,
    output logic [WIDTH-1:0] value_o,
    output logic [CW-1:0]    count_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             overrun_o
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shifted;
    logic             transfer;
    logic             complete;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {value_o[WIDTH-2:0], bit_i};
            assign bit_o   = value_o[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {bit_i, value_o[WIDTH-1:1]};
            assign bit_o   = value_o[0];
        end
    endgenerate

    assign transfer = word_valid_o && word_ready_i;
    // Only a real advance (not masked by clear or load) can finish a word.
    assign complete = !clear_i && !load_i && advance_i && (count_o == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_o      <= '0;
            count_o      <= '0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else if (clear_i) begin
            // Clear also empties the output word so no stale data survives a clear.
            value_o      <= '0;
            count_o      <= '0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (load_i) begin
                value_o <= load_data_i;
                count_o <= '0;
            end else if (advance_i) begin
                value_o <= shifted;
                count_o <= (count_o == LAST) ? '0 : count_o + CW'(1);
            end

            if (complete) begin
                word_o       <= shifted;
                word_valid_o <= 1'b1;
                if (word_valid_o && !transfer) begin
                    overrun_o <= 1'b1;
                end
            end else if (transfer) begin
                word_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_register_serdes.sv
// Scoreboard bench for shift_register_serdes: one MSB-first and one LSB-first instance share
// stimulus; a word-level model predicts state and transferred words, a monitor checks transfers.
module tb_shift_register_serdes;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_data;
    logic         advance;
    logic         bit_in;
    logic         word_ready;

    logic         bit_m, bit_l;
    logic [W-1:0] value_m, value_l, word_m, word_l;
    logic [2:0]   count_m, count_l;
    logic         valid_m, valid_l, ovr_m, ovr_l;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] sb_m[$];
    logic [W-1:0] sb_l[$];

    int m_val_m, m_val_l, m_word_m, m_word_l, m_count;
    bit m_valid, m_ovr;

    shift_register_serdes #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load), .load_data_i(load_data),
        .advance_i(advance), .bit_i(bit_in), .bit_o(bit_m), .value_o(value_m), .count_o(count_m),
        .word_valid_o(valid_m), .word_ready_i(word_ready), .word_o(word_m), .overrun_o(ovr_m)
    );

    shift_register_serdes #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .load_i(load), .load_data_i(load_data),
        .advance_i(advance), .bit_i(bit_in), .bit_o(bit_l), .value_o(value_l), .count_o(count_l),
        .word_valid_o(valid_l), .word_ready_i(word_ready), .word_o(word_l), .overrun_o(ovr_l)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        m_val_m = 0; m_val_l = 0; m_word_m = 0; m_word_l = 0;
        m_count = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic compareModel();
        checkOutput("value_msb", value_m, m_val_m);
        checkOutput("value_lsb", value_l, m_val_l);
        checkOutput("count_msb", count_m, m_count);
        checkOutput("count_lsb", count_l, m_count);
        checkOutput("bit_o_msb", bit_m, (m_val_m >> (W - 1)) % 2);
        checkOutput("bit_o_lsb", bit_l, m_val_l % 2);
        checkOutput("valid_msb", valid_m, m_valid);
        checkOutput("valid_lsb", valid_l, m_valid);
        checkOutput("word_msb", word_m, m_word_m);
        checkOutput("word_lsb", word_l, m_word_l);
        checkOutput("overrun_msb", ovr_m, m_ovr);
        checkOutput("overrun_lsb", ovr_l, m_ovr);
    endtask

    // Drive one cycle of inputs, advance the model, then compare state just after the edge.
    task automatic applyStimulus(input bit clr, input bit ld, input int ldata,
                                 input bit adv, input bit b, input bit rdy);
        bit xfer, comp;
        @(negedge clk);
        clear = clr; load = ld; load_data = ldata[W-1:0];
        advance = adv; bit_in = b; word_ready = rdy;

        xfer = m_valid && rdy;
        if (xfer) begin
            sb_m.push_back(m_word_m[W-1:0]);
            sb_l.push_back(m_word_l[W-1:0]);
        end
        if (clr) begin
            resetModel();
        end else begin
            comp = !ld && adv && (m_count == W - 1);
            if (ld) begin
                m_val_m = ldata % (1 << W);
                m_val_l = ldata % (1 << W);
                m_count = 0;
            end else if (adv) begin
                m_val_m = (m_val_m * 2 + b) % (1 << W);
                m_val_l = m_val_l / 2 + b * (1 << (W - 1));
                m_count = (m_count + 1) % W;
            end
            if (comp) begin
                if (m_valid && !rdy) m_ovr = 1;
                m_word_m = m_val_m;
                m_word_l = m_val_l;
                m_valid  = 1;
            end else if (xfer) begin
                m_valid = 0;
            end
        end

        @(posedge clk);
        #1;
        compareModel();
    endtask

    task automatic shiftWord(input logic [W-1:0] w, input bit rdyLast);
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(0, 0, 0, 1, w[i], (i == 0) ? rdyLast : 1'b0);
        end
    endtask

    // Monitor: any accepted word must match the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && valid_m && word_ready) begin
                if (sb_m.size() == 0) checkOutput("sb_msb_unexpected", 1, 0);
                else checkOutput("sb_word_msb", word_m, sb_m.pop_front());
            end
            if (rst_n && valid_l && word_ready) begin
                if (sb_l.size() == 0) checkOutput("sb_lsb_unexpected", 1, 0);
                else checkOutput("sb_word_lsb", word_l, sb_l.pop_front());
            end
        end
    end

    initial begin
        logic bitSeq[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        logic [W-1:0] firstWord = 8'hA5;

        rst_n = 0; clear = 0; load = 0; load_data = '0;
        advance = 0; bit_in = 0; word_ready = 0;
        resetModel();
        #12;
        compareModel();
        @(negedge clk);
        rst_n = 1;

        $display("[TB] MSB-first word capture");
        shiftWord(firstWord, 0);
        checkOutput("t1_word", word_m, 8'hA5);
        checkOutput("t1_valid", valid_m, 1);
        checkOutput("t1_count", count_m, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t1_valid_drop", valid_m, 0);

        $display("[TB] LSB-first load and shift out");
        applyStimulus(0, 1, 'h3C, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_bit_o", bit_l, bitSeq[i]);
            applyStimulus(0, 0, 0, 1, 0, 0);
        end
        checkOutput("t2_value", value_l, 0);

        $display("[TB] overrun and clear");
        applyStimulus(1, 0, 0, 0, 0, 0);
        shiftWord(8'h5A, 0);
        shiftWord(8'hC3, 0);
        checkOutput("t3_word", word_m, 8'hC3);
        checkOutput("t3_overrun", ovr_m, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("t3_word_clr", word_m, 0);
        checkOutput("t3_overrun_clr", ovr_m, 0);

        $display("[TB] transfer coincident with completion");
        shiftWord(8'h5A, 0);
        shiftWord(8'h96, 1);
        checkOutput("t4_valid", valid_m, 1);
        checkOutput("t4_overrun", ovr_m, 0);
        checkOutput("t4_word", word_m, 8'h96);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] load wins over advance");
        applyStimulus(0, 1, 'hFF, 1, 0, 0);
        checkOutput("t5_value", value_m, 8'hFF);
        checkOutput("t5_count", count_m, 0);

        $display("[TB] asynchronous reset mid-word");
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 0);
        clear = 0; load = 0; advance = 0; bit_in = 0; word_ready = 0;
        #2;
        rst_n = 0;
        #1;
        checkOutput("t6_value", value_m, 0);
        checkOutput("t6_count", count_m, 0);
        resetModel();
        compareModel();
        @(negedge clk);
        #2;
        rst_n = 1;
        shiftWord(8'hB4, 0);
        checkOutput("t6_word", word_m, 8'hB4);
        checkOutput("t6_count_after", count_m, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
                          int'($urandom_range(0, 255)), ($urandom_range(0, 99) < 70),
                          1'($urandom), ($urandom_range(0, 99) < 40));
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("sb_drain_msb", sb_m.size(), 0);
        checkOutput("sb_drain_lsb", sb_l.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
